// File: rtl/axis_shutdown_ctrl.sv
// -----------------------------------------------------------------------------
// axis_shutdown_ctrl
//
// Initiator side of the shutdown_req/shutdown_ack four-phase handshake. The
// block raises shutdown_req towards a group of stream shutdown gates, waits for
// their acks, and reports when the group is fully quiesced (done) or released
// again. A programmable per-phase timeout flags gates that do not answer; it
// only reports and never forces a state change.
//
// Ports:
//   clk             control clock
//   rst_n           asynchronous active-low reset
//   cmd_shutdown    level request: 1 = shut the group down, 0 = run
//   channel_mask    participating channels, captured on IDLE->ENTERING
//   timeout_cycles  per-phase timeout in clk cycles, 0 disables it
//   shutdown_req    request to each gate (registered)
//   shutdown_ack    ack from each gate, may be asynchronous to clk
//   busy            ENTERING or LEAVING phase in progress
//   done            all participating channels acked, group is shut down
//   timed_out       sticky timeout flag, cleared on the next IDLE->ENTERING
//   timeout_mask    sticky per-channel record of gates that did not answer
//   ack_status      synchronized acks, unmasked
// -----------------------------------------------------------------------------
module axis_shutdown_ctrl #(
    parameter int C_NUM_CHANNELS  = 4,
    parameter int C_TIMEOUT_WIDTH = 16,
    parameter int C_SYNC_STAGES   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_shutdown,
    input  logic [C_NUM_CHANNELS-1:0]  channel_mask,
    input  logic [C_TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic [C_NUM_CHANNELS-1:0]  shutdown_req,
    input  logic [C_NUM_CHANNELS-1:0]  shutdown_ack,
    output logic                       busy,
    output logic                       done,
    output logic                       timed_out,
    output logic [C_NUM_CHANNELS-1:0]  timeout_mask,
    output logic [C_NUM_CHANNELS-1:0]  ack_status
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTERING = 2'd1,
        SHUTDOWN = 2'd2,
        LEAVING  = 2'd3
    } state_t;

    localparam logic [C_TIMEOUT_WIDTH-1:0] CNT_ONE = C_TIMEOUT_WIDTH'(1);
    localparam logic [C_TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    state_t                       state_q, state_d;
    logic [C_NUM_CHANNELS-1:0]    ack_s;
    logic [C_NUM_CHANNELS-1:0]    mask_l, mask_d;
    logic [C_TIMEOUT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [C_NUM_CHANNELS-1:0]    req_d, tmask_d;
    logic                         busy_d, done_d, to_d;
    logic                         all_set, all_clr, timeout_hit;

    // ------------------------------------------------------------------
    // Ack synchronizer: a plain flop chain per bit, bypassed when the
    // gates share clk.
    // ------------------------------------------------------------------
    generate
        if (C_SYNC_STAGES == 0) begin : g_nosync
            assign ack_s = shutdown_ack;
        end else begin : g_sync
            logic [C_NUM_CHANNELS-1:0] sync_q [C_SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= shutdown_ack;
                    for (int i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign ack_s = sync_q[C_SYNC_STAGES-1];
        end
    endgenerate

    assign ack_status = ack_s;

    // Unmasked channels count as "set" for entry and as "clear" for exit.
    assign all_set = &(ack_s | ~mask_l);
    assign all_clr = ~|(ack_s & mask_l);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Completion beats abort in ENTERING; a
    // re-asserted command during LEAVING waits for IDLE.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (cmd_shutdown)  state_d = ENTERING;
            ENTERING: if (all_set)       state_d = SHUTDOWN;
                      else if (!cmd_shutdown) state_d = LEAVING;
            SHUTDOWN: if (!cmd_shutdown) state_d = LEAVING;
            LEAVING:  if (all_clr)       state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Computes the next value of every registered
    // output from the next state, so outputs line up with the state.
    // ------------------------------------------------------------------
    always_comb begin
        mask_d  = mask_l;
        cnt_d   = cnt_q;
        req_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        to_d    = timed_out;
        tmask_d = timeout_mask;

        timeout_hit = (timeout_cycles != '0)
                   && (cnt_q == timeout_cycles - CNT_ONE)
                   && (((state_q == ENTERING) && !all_set)
                    || ((state_q == LEAVING)  && !all_clr));

        if ((state_q == IDLE) && (state_d == ENTERING)) begin
            // New handshake: capture the group and forget old timeouts.
            mask_d  = channel_mask;
            to_d    = 1'b0;
            tmask_d = '0;
        end else if (timeout_hit) begin
            to_d = 1'b1;
            if (state_q == ENTERING) tmask_d = timeout_mask | (mask_l & ~ack_s);
            else                     tmask_d = timeout_mask | (mask_l & ack_s);
        end

        // Counter restarts on entry to a handshake phase, then saturates.
        if ((state_d != state_q) && ((state_d == ENTERING) || (state_d == LEAVING))) begin
            cnt_d = '0;
        end else if (((state_q == ENTERING) || (state_q == LEAVING)) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        unique case (state_d)
            ENTERING: begin req_d = mask_d; busy_d = 1'b1; end
            SHUTDOWN: begin req_d = mask_d; done_d = 1'b1; end
            LEAVING:  busy_d = 1'b1;
            default:  ;
        endcase
    end

    // Registered outputs and datapath; reset drops req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_l       <= '0;
            cnt_q        <= '0;
            shutdown_req <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            timeout_mask <= '0;
        end else begin
            mask_l       <= mask_d;
            cnt_q        <= cnt_d;
            shutdown_req <= req_d;
            busy         <= busy_d;
            done         <= done_d;
            timed_out    <= to_d;
            timeout_mask <= tmask_d;
        end
    end

endmodule

// File: tb/tb_axis_shutdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_shutdown_ctrl
//
// Directed bench for axis_shutdown_ctrl (4 channels, 2-stage ack sync).
// Inputs are driven 1 ns after the rising edge and outputs sampled at the same
// point, i.e. each vector shows the registered result of one clock edge.
// -----------------------------------------------------------------------------
module tb_axis_shutdown_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_shutdown;
    logic [N-1:0]  channel_mask;
    logic [W-1:0]  timeout_cycles;
    logic [N-1:0]  shutdown_req;
    logic [N-1:0]  shutdown_ack;
    logic          busy;
    logic          done;
    logic          timed_out;
    logic [N-1:0]  timeout_mask;
    logic [N-1:0]  ack_status;

    int n_checks = 0;
    int n_fail   = 0;

    axis_shutdown_ctrl #(
        .C_NUM_CHANNELS  (N),
        .C_TIMEOUT_WIDTH (W),
        .C_SYNC_STAGES   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_shutdown   (cmd_shutdown),
        .channel_mask   (channel_mask),
        .timeout_cycles (timeout_cycles),
        .shutdown_req   (shutdown_req),
        .shutdown_ack   (shutdown_ack),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .timeout_mask   (timeout_mask),
        .ack_status     (ack_status)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         cmd;
        logic [N-1:0] mask;
        logic [W-1:0] tmo;
        logic [N-1:0] ack;
        logic [N-1:0] req;
        logic         busy;
        logic         done;
        logic         to;
        logic [N-1:0] tmask;
        logic [N-1:0] acks;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic [N-1:0] m, logic [W-1:0] t, logic [N-1:0] a,
                                logic [N-1:0] r, logic b, logic d, logic o,
                                logic [N-1:0] tm, logic [N-1:0] s);
        vec_t v;
        v.cmd = c; v.mask = m; v.tmo = t; v.ack = a;
        v.req = r; v.busy = b; v.done = d; v.to = o; v.tmask = tm; v.acks = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [N-1:0] r, input logic b,
                              input logic d, input logic o, input logic [N-1:0] tm,
                              input logic [N-1:0] s);
        check({name, ".req"},   32'(shutdown_req), 32'(r));
        check({name, ".busy"},  32'(busy),         32'(b));
        check({name, ".done"},  32'(done),         32'(d));
        check({name, ".to"},    32'(timed_out),    32'(o));
        check({name, ".tmask"}, 32'(timeout_mask), 32'(tm));
        check({name, ".acks"},  32'(ack_status),   32'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        tick();
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        tick();
        while ((busy || done) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(busy | done), 32'd0);
    endtask

    initial begin
        // Full group, no timeout: gates ack 5 cycles into ENTERING.
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'hF, 0, 4'h0,  4'hF, 1, 0, 0, 4'h0, 4'h0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 4'hF, 0, 4'h0,  4'hF, 1, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'hF, 0, 4'hF,  4'hF, 1, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'hF, 0, 4'hF,  4'hF, 1, 0, 0, 4'h0, 4'hF));
        vecs.push_back(mk(1, 4'hF, 0, 4'hF,  4'hF, 0, 1, 0, 4'h0, 4'hF));
        vecs.push_back(mk(1, 4'hF, 0, 4'hF,  4'hF, 0, 1, 0, 4'h0, 4'hF));
        vecs.push_back(mk(0, 4'hF, 0, 4'hF,  4'h0, 1, 0, 0, 4'h0, 4'hF));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 1, 0, 0, 4'h0, 4'hF));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 1, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 0, 0, 0, 4'h0, 4'h0));
        // Partial group 0101; mask change in SHUTDOWN ignored; unmasked ch1 ack ignored.
        vecs.push_back(mk(1, 4'h5, 0, 4'h0,  4'h5, 1, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'h5, 0, 4'h5,  4'h5, 1, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'h5, 0, 4'h5,  4'h5, 1, 0, 0, 4'h0, 4'h5));
        vecs.push_back(mk(1, 4'h5, 0, 4'h5,  4'h5, 0, 1, 0, 4'h0, 4'h5));
        vecs.push_back(mk(1, 4'hF, 0, 4'h5,  4'h5, 0, 1, 0, 4'h0, 4'h5));
        vecs.push_back(mk(0, 4'hF, 0, 4'h5,  4'h0, 1, 0, 0, 4'h0, 4'h5));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2,  4'h0, 1, 0, 0, 4'h0, 4'h5));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2,  4'h0, 1, 0, 0, 4'h0, 4'h2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2,  4'h0, 0, 0, 0, 4'h0, 4'h2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 0, 0, 0, 4'h0, 4'h2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h0,  4'h0, 0, 0, 0, 4'h0, 4'h0));

        rst_n          = 1'b0;
        cmd_shutdown   = 1'b0;
        channel_mask   = '0;
        timeout_cycles = '0;
        shutdown_ack   = '0;
        #3;
        check_outs("reset", 4'h0, 0, 0, 0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven part.
        foreach (vecs[i]) begin
            cmd_shutdown   = vecs[i].cmd;
            channel_mask   = vecs[i].mask;
            timeout_cycles = vecs[i].tmo;
            shutdown_ack   = vecs[i].ack;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].busy, vecs[i].done,
                       vecs[i].to, vecs[i].tmask, vecs[i].acks);
        end

        // ENTERING timeout: ch2 silent, timeout 10, flag set after cycle 10.
        channel_mask   = 4'hF;
        timeout_cycles = 16'd10;
        shutdown_ack   = 4'hB;
        cmd_shutdown   = 1'b1;
        tick();                                         // ENTERING cycle 1
        check("tmo.busy_c1", 32'(busy), 32'd1);
        repeat (8) tick();                              // cycle 9
        check("tmo.flag_c9", 32'(timed_out), 32'd0);
        repeat (2) tick();                              // cycle 11
        check("tmo.flag_c11", 32'(timed_out), 32'd1);
        check("tmo.mask_c11", 32'(timeout_mask), 32'h4);
        check("tmo.busy_c11", 32'(busy), 32'd1);
        check("tmo.done_c11", 32'(done), 32'd0);
        repeat (9) tick();                              // cycle 20
        shutdown_ack = 4'hF;
        repeat (2) tick();
        check("tmo.done_early", 32'(done), 32'd0);
        tick();
        check("tmo.done_late", 32'(done), 32'd1);
        check("tmo.flag_sticky", 32'(timed_out), 32'd1);
        check("tmo.mask_sticky", 32'(timeout_mask), 32'h4);
        cmd_shutdown = 1'b0;
        shutdown_ack = 4'h0;
        wait_idle("tmo.release", 20);

        // Abort after 3 ENTERING cycles with no acks.
        timeout_cycles = 16'd0;
        cmd_shutdown   = 1'b1;
        tick();
        check("abort.req", 32'(shutdown_req), 32'hF);
        check("abort.flag_clr", 32'(timed_out), 32'd0);
        check("abort.mask_clr", 32'(timeout_mask), 32'h0);
        repeat (2) tick();
        check("abort.done_ent", 32'(done), 32'd0);
        cmd_shutdown = 1'b0;
        tick();
        check("abort.leave_req", 32'(shutdown_req), 32'h0);
        check("abort.leave_busy", 32'(busy), 32'd1);
        check("abort.leave_done", 32'(done), 32'd0);
        tick();
        check("abort.idle_busy", 32'(busy), 32'd0);
        check("abort.idle_done", 32'(done), 32'd0);

        // cmd re-asserted in LEAVING while ch0 ack stays high for 8 cycles,
        // plus a LEAVING timeout (3 cycles) on ch0.
        channel_mask   = 4'h1;
        timeout_cycles = 16'd3;
        shutdown_ack   = 4'h1;
        cmd_shutdown   = 1'b1;
        wait_done("reas.enter", 10);
        check("reas.no_entry_to", 32'(timed_out), 32'd0);
        cmd_shutdown = 1'b0;
        tick();
        check("reas.leave_req", 32'(shutdown_req), 32'h0);
        cmd_shutdown = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("reas.hold%0d.busy", i), 32'(busy), 32'd1);
            check($sformatf("reas.hold%0d.req", i), 32'(shutdown_req), 32'h0);
        end
        check("reas.leave_to", 32'(timed_out), 32'd1);
        check("reas.leave_tmask", 32'(timeout_mask), 32'h1);
        shutdown_ack = 4'h0;
        repeat (2) tick();
        check("reas.still_leaving", 32'(busy), 32'd1);
        tick();
        check("reas.idle_busy", 32'(busy), 32'd0);
        check("reas.idle_done", 32'(done), 32'd0);
        check("reas.idle_flag", 32'(timed_out), 32'd1);
        tick();
        check("reas.reenter_busy", 32'(busy), 32'd1);
        check("reas.reenter_req", 32'(shutdown_req), 32'h1);
        check("reas.reenter_flag", 32'(timed_out), 32'd0);
        check("reas.reenter_tmask", 32'(timeout_mask), 32'h0);
        cmd_shutdown = 1'b0;
        wait_idle("reas.release", 20);

        // Empty mask: one ENTERING cycle, then SHUTDOWN; then reset mid-state.
        timeout_cycles = 16'd0;
        channel_mask   = 4'h0;
        shutdown_ack   = 4'hF;
        cmd_shutdown   = 1'b1;
        tick();
        check("empty.ent_busy", 32'(busy), 32'd1);
        check("empty.ent_req", 32'(shutdown_req), 32'h0);
        tick();
        check("empty.sd_done", 32'(done), 32'd1);
        check("empty.sd_busy", 32'(busy), 32'd0);
        check("empty.sd_req", 32'(shutdown_req), 32'h0);
        repeat (2) tick();
        check("empty.acks", 32'(ack_status), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'h0, 0, 0, 0, 4'h0, 4'h0);
        cmd_shutdown = 1'b0;
        shutdown_ack = 4'h0;
        tick();
        rst_n = 1'b1;
        tick();
        check_outs("post_rst", 4'h0, 0, 0, 0, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_shutdown_ctrl.md
Name: axis_shutdown_ctrl

Overview:
Initiator side of the shutdown_req/shutdown_ack four-phase handshake used by the stream shutdown gates. It drives shutdown_req to up to C_NUM_CHANNELS gates and collects their acks. It reports when the whole group is quiesced or released, and flags gates that fail to answer within a programmable timeout. It sits in the control domain, typically driven by a register bank bit, and fans out to the gates.

Parameters:
C_NUM_CHANNELS, 4, number of req/ack pairs (1..32)
C_TIMEOUT_WIDTH, 16, width of timeout counter and timeout_cycles
C_SYNC_STAGES, 2, ack synchronizer depth on clk; 0 = acks used directly (same clock)

Ports:
clk  in  1  control clock
rst_n  in  1  asynchronous active-low reset
cmd_shutdown  in  1  level; 1 = group shall be shut down, 0 = running
channel_mask  in  C_NUM_CHANNELS  1 = channel participates; sampled on IDLE->ENTERING
timeout_cycles  in  C_TIMEOUT_WIDTH  per-phase timeout in clk cycles; 0 = disabled
shutdown_req  out  C_NUM_CHANNELS  request to each gate
shutdown_ack  in  C_NUM_CHANNELS  ack from each gate (may be asynchronous to clk)
busy  out  1  handshake phase in progress (ENTERING or LEAVING)
done  out  1  all masked channels acked; group is shut down
timed_out  out  1  sticky timeout flag
timeout_mask  out  C_NUM_CHANNELS  sticky; masked channels not answering at timeout
ack_status  out  C_NUM_CHANNELS  synchronized acks, raw (unmasked)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; latched mask 0; counter 0.
- Ack path: C_SYNC_STAGES flop chain per bit; all decisions use the synced value ack_s. ack_status = ack_s.
- all_set = &(ack_s | ~mask_l); all_clr = ~|(ack_s & mask_l).
- IDLE: req = 0. cmd_shutdown=1 -> ENTERING. On this transition: mask_l <= channel_mask; counter <= 0; timed_out and timeout_mask cleared.
- ENTERING: req = mask_l, registered, high from the first ENTERING cycle (1 cycle after cmd seen). all_set -> SHUTDOWN. Else cmd_shutdown=0 -> LEAVING (abort). all_set has priority over abort in the same cycle.
- SHUTDOWN: req = mask_l; done = 1. cmd_shutdown=0 -> LEAVING.
- LEAVING: req = 0. all_clr -> IDLE. cmd_shutdown re-asserted mid-LEAVING is ignored until IDLE is reached; IDLE then re-enters ENTERING next cycle.
- Entry to ENTERING or LEAVING clears the counter.
- Counter: +1 per cycle in ENTERING/LEAVING, saturating at all-ones.
- Timeout condition: timeout_cycles != 0, counter == timeout_cycles-1, and phase not complete.
  - ENTERING timeout: timed_out <= 1; timeout_mask |= mask_l & ~ack_s.
  - LEAVING timeout: timed_out <= 1; timeout_mask |= mask_l & ack_s.
  - Timeout only flags; FSM keeps waiting (no forced transition).
- busy = state in {ENTERING, LEAVING}. done = state==SHUTDOWN. All outputs are registered.
- mask_l = 0: ENTERING completes on its first cycle (all_set trivially true); LEAVING likewise.
- channel_mask changes outside IDLE->ENTERING have no effect. Unmasked req bits stay 0.
- Acks from unmasked channels are ignored for all_set/all_clr/timeout_mask.
- Reset mid-handshake: req drops to 0 asynchronously. Gates must tolerate req removal; no completion is reported.

Test Plan:
- N=4, SYNC=2, mask=4'b1111, timeout=0. Set cmd=1; gates ack after 5 cycles -> req=1111 one cycle after cmd; done=1 at ack_s+1 (ack+3 cycles); busy high in between. Clear cmd -> req=0; done=0; IDLE after acks drop.
- mask=4'b0101, only ch0/ch2 ack; ch1/ch3 acks held 0 -> done=1, req=0101, timed_out=0.
- timeout=10, ch2 never acks -> timed_out=1 on 10th ENTERING cycle; timeout_mask=0100; state stays ENTERING. Ch2 acks at cycle 20 -> done=1 with timed_out still 1.
- Abort: cmd=1, then cmd=0 after 3 cycles with no acks -> LEAVING; req=0; IDLE once all_clr; done never 1.
- cmd re-asserted during LEAVING while ch0 ack held high 8 cycles -> stays LEAVING until ack drops; IDLE for 1 cycle; then ENTERING with flags cleared.
- mask=0, cmd=1 -> ENTERING for 1 cycle, then SHUTDOWN; done=1; req=0. Assert rst_n=0 in SHUTDOWN -> all outputs 0 immediately.
